// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encodings and default bus widths.
// The completer uses the same state encodings.
package apb_pkg;

    localparam int unsigned AddrWDefault = 32;
    localparam int unsigned DataWDefault = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_if.sv
// APB bus between one requester (master) and one completer (slave).
interface apb_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter. expired_o flags the last allowed wait cycle;
// with TIMEOUT=0 it never fires.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned     CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LastCnt);
endmodule

// File: rtl/apb_requester.sv
// APB requester: turns single valid/ready commands into IDLE/SETUP/ACCESS
// transfers and reports each completion as a one-cycle response pulse.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = AddrWDefault,
    parameter int unsigned DATA_W  = DataWDefault,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    apb_if.master             apb
);
    apb_state_e        state_d, state_q;
    logic [ADDR_W-1:0] paddr_d, paddr_q;
    logic [DATA_W-1:0] pwdata_d, pwdata_q;
    logic              pwrite_d, pwrite_q;
    logic              psel_d, psel_q;
    logic              penable_d, penable_q;
    logic              rsp_valid_d, rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
    logic              rsp_err_d, rsp_err_q;
    logic              rsp_timeout_d, rsp_timeout_q;

    logic timer_clear, timer_en, timer_expired;

    assign timer_clear = (state_q == StSetup);
    assign timer_en    = (state_q == StAccess) && !apb.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (pclk),
        .rst_ni    (presetn),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                if (apb.pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : apb.prdata;
                    rsp_err_d     = apb.pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = StIdle;
                end else if (timer_expired) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= StIdle;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // cmd_ready is the only output decoded straight from state.
    assign cmd_ready   = (state_q == StIdle);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign apb.paddr   = paddr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester against a small memory-backed APB completer
// with programmable wait states, error response and hang.
module tb_apb_requester;
    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    int unsigned cfg_waits = 0;
    logic        cfg_err = 1'b0;
    logic        cfg_hang = 1'b0;
    int unsigned wait_cnt;
    logic [31:0] mem [16];

    always #5 pclk = ~pclk;

    apb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_requester #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (bus)
    );

    // Completer model
    always_comb begin
        bus.pready  = bus.psel && bus.penable && !cfg_hang && (wait_cnt >= cfg_waits);
        bus.prdata  = mem[bus.paddr[5:2]];
        bus.pslverr = cfg_err;
    end

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt <= 0;
        end else if (bus.psel && bus.penable && !bus.pready) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
            mem[bus.paddr[5:2]] <= bus.pwdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Issues one command and follows it until rsp_valid (cycle 1 = first cycle after accept).
    task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            output int lat, output int psel_cyc, output int pen_cyc,
                            output logic stable);
        lat      = 0;
        psel_cyc = 0;
        pen_cyc  = 0;
        stable   = 1'b1;
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFF0;
        cmd_wdata = 32'h0BAD_0BAD;
        for (int c = 1; c <= 40; c++) begin
            if (bus.psel) begin
                psel_cyc++;
                if (bus.paddr !== addr || bus.pwrite !== wr) stable = 1'b0;
                if (wr && bus.pwdata !== wdata) stable = 1'b0;
            end
            if (bus.penable) pen_cyc++;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            step();
        end
    endtask

    int   lat, ps, pe;
    logic st;
    logic seen;

    initial begin
        // Reset state
        #12;
        check("rst_psel", {31'b0, bus.psel}, 32'd0);
        check("rst_penable", {31'b0, bus.penable}, 32'd0);
        check("rst_pwrite", {31'b0, bus.pwrite}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
        check("rst_paddr", bus.paddr, 32'd0);
        check("rst_pwdata", bus.pwdata, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge pclk);
        presetn = 1'b1;
        step();

        // Zero-wait write
        run_xfer(32'h4, 1'b1, 32'hDEAD_BEEF, lat, ps, pe, st);
        check("w1_latency", lat, 32'd3);
        check("w1_psel_cycles", ps, 32'd2);
        check("w1_penable_cycles", pe, 32'd1);
        check("w1_stable", {31'b0, st}, 32'd1);
        check("w1_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
        check("w1_rdata", rsp_rdata, 32'd0);
        check("w1_ready_with_rsp", {31'b0, cmd_ready}, 32'd1);
        step();
        check("w1_pulse_one_cycle", {31'b0, rsp_valid}, 32'd0);
        check("w1_paddr_kept", bus.paddr, 32'h4);

        // Read back
        run_xfer(32'h4, 1'b0, 32'h0, lat, ps, pe, st);
        check("r1_latency", lat, 32'd3);
        check("r1_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("r1_err", {31'b0, rsp_err}, 32'd0);
        step();

        run_xfer(32'h10, 1'b1, 32'h1234_5678, lat, ps, pe, st);
        check("w2_latency", lat, 32'd3);
        step();

        // Read with 3 wait states
        cfg_waits = 3;
        run_xfer(32'h10, 1'b0, 32'h0, lat, ps, pe, st);
        check("r2_latency", lat, 32'd6);
        check("r2_psel_cycles", ps, 32'd5);
        check("r2_paddr_stable", {31'b0, st}, 32'd1);
        check("r2_rdata", rsp_rdata, 32'h1234_5678);
        check("r2_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
        step();
        check("r2_pulse_one_cycle", {31'b0, rsp_valid}, 32'd0);
        check("r2_rdata_held", rsp_rdata, 32'h1234_5678);
        cfg_waits = 0;

        // Timeout: completer never ready
        cfg_hang = 1'b1;
        run_xfer(32'h20, 1'b0, 32'h0, lat, ps, pe, st);
        check("to_latency", lat, 32'd6);
        check("to_penable_cycles", pe, 32'd4);
        check("to_err", {31'b0, rsp_err}, 32'd1);
        check("to_timeout", {31'b0, rsp_timeout}, 32'd1);
        check("to_rdata", rsp_rdata, 32'd0);
        check("to_psel", {31'b0, bus.psel}, 32'd0);
        check("to_ready", {31'b0, cmd_ready}, 32'd1);
        step();
        check("to_flags_held", {30'b0, rsp_err, rsp_timeout}, 32'd3);
        cfg_hang = 1'b0;

        // Slave error on write
        cfg_err = 1'b1;
        run_xfer(32'h8, 1'b1, 32'hA5A5_A5A5, lat, ps, pe, st);
        check("se_latency", lat, 32'd3);
        check("se_err", {31'b0, rsp_err}, 32'd1);
        check("se_timeout", {31'b0, rsp_timeout}, 32'd0);
        check("se_rdata", rsp_rdata, 32'd0);
        cfg_err = 1'b0;
        step();

        // Reset in the middle of ACCESS
        cfg_hang  = 1'b1;
        cmd_addr  = 32'h4;
        cmd_write = 1'b0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("mr_in_access", {30'b0, bus.psel, bus.penable}, 32'd3);
        #2;
        presetn = 1'b0;
        #1;
        check("mr_async_drop", {30'b0, bus.psel, bus.penable}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        cfg_hang = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        check("mr_no_rsp", {31'b0, seen}, 32'd0);
        check("mr_paddr_cleared", bus.paddr, 32'd0);

        run_xfer(32'h4, 1'b0, 32'h0, lat, ps, pe, st);
        check("post_rst_latency", lat, 32'd3);
        check("post_rst_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("post_rst_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
